// File: rtl/cmd_player.sv
// cmd_player: streams stored commands from command memory into the UART TX FIFO; CMD_PLAYER_GAP_EN adds an idle gap between commands
module cmd_player #(
  parameter int CMD_WIDTH  = 32,
  parameter int CMD_DEPTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = $clog2(CMD_DEPTH*CMD_WIDTH+1),
  parameter int GAP_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         tx_valid,
  output logic [DATA_WIDTH-1:0]        tx_data,
  input  logic                         tx_full,
  output logic [$clog2(CMD_DEPTH)-1:0] cmd_idx,
  output logic                         error_pulse,
  output logic [1:0]                   error_code
);
  localparam int IW = $clog2(CMD_DEPTH);
  localparam int BW = $clog2(CMD_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);
  typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, RD_BYTE, WAIT_BYTE, PUSH, FIN
`ifdef CMD_PLAYER_GAP_EN
    , GAP
`endif
  } state_t;
`ifdef CMD_PLAYER_GAP_EN
  localparam state_t NEXT = GAP;
  localparam int GW = $clog2(GAP_CYCLES+1);
  logic [GW-1:0] gap_q, gap_d;
`else
  localparam state_t NEXT = RD_BYTE;
`endif
  state_t state_q, state_d;
  logic [IW-1:0] cmd_idx_q, cmd_idx_d, last_q, last_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic is_lf, last_byte, eoc;
  assign cmd_idx   = cmd_idx_q;
  assign is_lf     = byte_q == LF;
  assign last_byte = byte_idx_q == BW'(CMD_WIDTH-1);
  assign eoc       = is_lf || last_byte;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_idx_q  <= '0;
      last_q     <= '0;
      byte_idx_q <= '0;
      byte_q     <= '0;
`ifdef CMD_PLAYER_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_idx_q  <= cmd_idx_d;
      last_q     <= last_d;
      byte_idx_q <= byte_idx_d;
      byte_q     <= byte_d;
`ifdef CMD_PLAYER_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end
  always_comb begin
    state_d     = state_q;
    cmd_idx_d   = cmd_idx_q;
    last_d      = last_q;
    byte_idx_d  = byte_idx_q;
    byte_d      = byte_q;
`ifdef CMD_PLAYER_GAP_EN
    gap_d       = gap_q;
`endif
    busy        = state_q != IDLE && state_q != FIN;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    error_pulse = 1'b0;
    error_code  = 2'd0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = RD_CNT;
        cmd_idx_d  = '0;
        byte_idx_d = '0;
      end
      RD_CNT: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT_CNT;
      end
      WAIT_CNT: begin
        state_d     = mem_rd_data == '0 ? FIN : RD_BYTE;
        error_pulse = mem_rd_data > DATA_WIDTH'(CMD_DEPTH);
        error_code  = error_pulse ? 2'd1 : 2'd0;
        last_d      = error_pulse ? IW'(CMD_DEPTH-1) : IW'(mem_rd_data - DATA_WIDTH'(1));
      end
      RD_BYTE: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(cmd_idx_q) * ADDR_W'(CMD_WIDTH) + ADDR_W'(byte_idx_q) + ADDR_W'(1);
        state_d   = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        byte_d  = mem_rd_data;
        state_d = PUSH;
      end
      PUSH: if (!tx_full) begin
        tx_valid    = 1'b1;
        tx_data     = byte_q;
        error_pulse = !is_lf && last_byte;
        error_code  = error_pulse ? 2'd2 : 2'd0;
        byte_idx_d  = eoc ? '0 : byte_idx_q + BW'(1);
        state_d     = !eoc ? RD_BYTE : cmd_idx_q == last_q ? FIN : NEXT;
        cmd_idx_d   = eoc && cmd_idx_q != last_q ? cmd_idx_q + IW'(1) : cmd_idx_q;
`ifdef CMD_PLAYER_GAP_EN
        gap_d       = '0;
`endif
      end
`ifdef CMD_PLAYER_GAP_EN
      GAP: begin
        state_d = gap_q == GW'(GAP_CYCLES-1) ? RD_BYTE : GAP;
        gap_d   = gap_q + GW'(1);
      end
`endif
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cmd_player.sv
// tb_cmd_player: randomized scoreboard bench for cmd_player with a slot-level reference model
module tb_cmd_player;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = $clog2(D*W+1);
`ifdef CMD_PLAYER_GAP_EN
  localparam int GAP = 10;
`else
  localparam int GAP = 0;
`endif
  logic clk = 0, rst = 1, start = 0, tx_full = 0;
  logic [7:0] mem_rd_data = 0;
  logic busy, done, mem_rd_en, tx_valid, error_pulse;
  logic [AW-1:0] mem_addr;
  logic [7:0] tx_data;
  logic [3:0] cmd_idx;
  logic [1:0] error_code;
  logic [7:0] mem [0:D*W];
  logic [7:0] exp_q [$];
  int err_q [$];
  int tests = 0, fails = 0, done_cnt = 0, exp_idx = 0, cyc = 0, lf_cyc = 0;
  bit lf_pend = 0;

  always #5 clk = ~clk;

  cmd_player #(.GAP_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_full(tx_full),
    .cmd_idx(cmd_idx), .error_pulse(error_pulse), .error_code(error_code)
  );

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) lf_pend = 0;
    else begin
      if (mem_rd_en && mem_addr != 0 && lf_pend) begin
        lf_pend = 0;
        if (GAP > 0) chk("gap_len", int'(cyc - lf_cyc - 1 >= GAP), 1);
        else chk("next_cmd_read_delay", cyc - lf_cyc, 1);
      end
      if (tx_valid) begin
        chk("tx_while_full", int'(tx_full), 0);
        chk("tx_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
        if (tx_data == 8'h0A) begin lf_pend = 1; lf_cyc = cyc; end
      end
      if (error_pulse) begin
        chk("err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) chk("err_code", int'(error_code), err_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        lf_pend = 0;
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic fill(input int cnt);
    mem[0] = 8'(cnt);
    for (int i = 0; i < D; i++) begin
      int len = $urandom_range(1, W + 1);
      for (int j = 0; j < W; j++) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'h0A) b = 8'h00;
        mem[i*W+j+1] = (j == len - 1) ? 8'h0A : b;
      end
    end
  endtask

  task automatic model();
    int cnt = int'(mem[0]);
    if (cnt > D) begin err_q.push_back(1); cnt = D; end
    exp_idx = cnt == 0 ? 0 : cnt - 1;
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < W; j++) begin
        exp_q.push_back(mem[i*W+j+1]);
        if (mem[i*W+j+1] == 8'h0A) break;
        if (j == W - 1) err_q.push_back(2);
      end
  endtask

  task automatic run(input int mode, input bit restart, output int lat);
    bit seen = 0;
    lat = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 1; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_after_start", int'(busy), 1);
      if (done) begin seen = 1; lat = c; end
      @(posedge clk); #1;
      tx_full = mode == 1 ? (c >= 20 && c < 70) : mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
      start = restart && c == 10;
    end
    tx_full = 0;
    start = 0;
    chk("done_seen", int'(seen), 1);
    repeat (5) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("errors_left", err_q.size(), 0);
    chk("cmd_idx_final", int'(cmd_idx), exp_idx);
    exp_q.delete();
    err_q.delete();
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_err", int'(error_pulse), 0);
    chk("rst_cmd_idx", int'(cmd_idx), 0);
    @(posedge clk); #1 rst = 0;
    fill(0); model(); run(0, 0, lat);
    chk("cnt0_latency_ok", int'(lat >= 3 && lat <= 5), 1);
    fill(2);
    mem[1] = 8'h41; mem[2] = 8'h54; mem[3] = 8'h0D; mem[4] = 8'h0A;
    mem[33] = 8'h41; mem[34] = 8'h54; mem[35] = 8'h2B; mem[36] = 8'h58; mem[37] = 8'h0D; mem[38] = 8'h0A;
    model();
    chk("model_at_len", exp_q.size(), 10);
    run(0, 0, lat);
    fill(3); model(); run(1, 0, lat);
    fill(1);
    for (int j = 1; j <= W; j++) mem[j] = 8'h41;
    model(); run(0, 0, lat);
    fill(20); model(); run(2, 1, lat);
    fill(5); model();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (30) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tx_valid", int'(tx_valid), 0);
    chk("abort_cmd_idx", int'(cmd_idx), 0);
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    err_q.delete();
    model(); run(0, 0, lat);
    for (int k = 0; k < 6; k++) begin
      fill($urandom_range(0, 20)); model(); run(2, 0, lat);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
